hybrid_noc_router_output: RTL and testbench

- Output stage of one hybrid NoC router port.
- Merges time-division-multiplexed (TDM) guaranteed traffic and best-effort (BE) wormhole traffic onto one output link.
- TDM input is selected per time slot by a runtime-writable LUT. BE packets from the BE inputs are arbitrated round-robin into a small output FIFO. BE flits use only link cycles not claimed by TDM.

---
 rtl/hybrid_noc_router_output_pkg.sv | 21 ++
 rtl/hybrid_noc_router_output_fifo.sv | 63 ++++++
 rtl/hybrid_noc_router_output.sv | 181 ++++++++++++++++++
 tb/tb_hybrid_noc_router_output.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hybrid_noc_router_output_pkg.sv
// Shared sizing helpers for the hybrid NoC router output stage.
// LUT entries reserve the value PORTS as the idle marker.
package hybrid_noc_router_output_pkg;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int lut_entry_w(input int ports);
        return clog2_min1(ports + 1);
    endfunction

    function automatic int slot_w(input int lut_size);
        return clog2_min1(lut_size);
    endfunction

    function automatic int idle_entry(input int ports);
        return ports;
    endfunction

endpackage

// File: rtl/hybrid_noc_router_output_fifo.sv
// Best-effort output FIFO: flit plus last marker, push/pop, full/empty.
// Storage is not reset; the count alone defines validity.
module noc_output_fifo
    import hybrid_noc_router_output_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_last,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_last,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2_min1(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_data [DEPTH];
    logic             mem_last [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem_data[rd_ptr];
    assign head_last = mem_last[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_data[wr_ptr] <= push_data;
            mem_last[wr_ptr] <= push_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop)  rd_ptr <= nxt(rd_ptr);
            if (do_push && !do_pop) count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/hybrid_noc_router_output.sv
// Output stage of a hybrid NoC router port: slot-scheduled TDM traffic
// merged with round-robin wormhole best-effort traffic on one link.
module hybrid_noc_router_output
    import hybrid_noc_router_output_pkg::*;
#(
    parameter int FLIT_WIDTH   = 32,
    parameter int PORTS        = 5,
    parameter int LUT_SIZE     = 16,
    parameter int BE_ENABLED   = 1,
    parameter int BE_PORTS     = 5,
    parameter int OUTPUT_ID    = 0,
    parameter int BUFFER_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [PORTS*FLIT_WIDTH-1:0]    tdm_in_flit,
    input  logic [PORTS-1:0]               tdm_in_valid,
    input  logic [PORTS-1:0]               tdm_in_last,
    input  logic [BE_PORTS*FLIT_WIDTH-1:0] be_in_flit,
    input  logic [BE_PORTS-1:0]            be_in_valid,
    input  logic [BE_PORTS-1:0]            be_in_last,
    output logic [BE_PORTS-1:0]            be_in_ready,
    output logic [FLIT_WIDTH-1:0]          out_flit,
    output logic                           out_last,
    output logic                           tdm_out_valid,
    output logic                           be_out_valid,
    input  logic                           be_out_ready,
    input  logic [lut_entry_w(PORTS)-1:0]  lut_conf_data,
    input  logic [clog2_min1(PORTS)-1:0]   lut_conf_sel,
    input  logic [slot_w(LUT_SIZE)-1:0]    lut_conf_slot,
    input  logic                           lut_conf_valid
);

    localparam int EW = lut_entry_w(PORTS);
    localparam int SW = slot_w(LUT_SIZE);
    localparam int PW = clog2_min1(PORTS);
    localparam int FW = FLIT_WIDTH;
    localparam logic [EW-1:0] IDLE = EW'(idle_entry(PORTS));

    logic [SW-1:0] slot;
    logic [EW-1:0] lut [LUT_SIZE];
    logic [EW-1:0] cur_entry;
    logic          tdm_hit;
    logic [FW-1:0] tdm_sel_flit;
    logic          tdm_sel_last;
    logic [FW-1:0] tdm_flit_q;
    logic          tdm_last_q;
    logic [FW-1:0] be_flit;
    logic          be_last;

    // Idle entries (>= PORTS) never match a port, so no range check is needed.
    always_comb begin
        cur_entry    = lut[slot];
        tdm_hit      = 1'b0;
        tdm_sel_flit = '0;
        tdm_sel_last = 1'b0;
        for (int p = 0; p < PORTS; p++) begin
            if (cur_entry == EW'(p) && tdm_in_valid[p]) begin
                tdm_hit      = 1'b1;
                tdm_sel_flit = tdm_in_flit[p*FW +: FW];
                tdm_sel_last = tdm_in_last[p];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot          <= '0;
            tdm_out_valid <= 1'b0;
            tdm_flit_q    <= '0;
            tdm_last_q    <= 1'b0;
            for (int i = 0; i < LUT_SIZE; i++) lut[i] <= IDLE;
        end else begin
            slot          <= slot + 1'b1;
            tdm_out_valid <= tdm_hit;
            tdm_flit_q    <= tdm_sel_flit;
            tdm_last_q    <= tdm_sel_last;
            if (lut_conf_valid && lut_conf_sel == PW'(OUTPUT_ID))
                lut[lut_conf_slot] <= lut_conf_data;
        end
    end

    assign out_flit = tdm_out_valid ? tdm_flit_q : be_flit;
    assign out_last = tdm_out_valid ? tdm_last_q : be_last;

    if (BE_ENABLED != 0) begin : g_be
        localparam int BW = clog2_min1(BE_PORTS);

        logic          grant_valid;
        logic [BW-1:0] grant_idx;
        logic [BW-1:0] rr_ptr;
        logic          pick_valid;
        logic [BW-1:0] pick_idx;
        logic          cur_valid;
        logic [BW-1:0] cur_idx;
        logic          fifo_full;
        logic          fifo_empty;
        logic          push;
        logic          pop;
        logic [FW-1:0] push_flit;
        logic          push_last;
        logic [FW-1:0] head_flit;
        logic          head_last;

        always_comb begin
            int idx;
            idx        = 0;
            pick_valid = 1'b0;
            pick_idx   = '0;
            for (int i = 0; i < BE_PORTS; i++) begin
                idx = (int'(rr_ptr) + i) % BE_PORTS;
                if (!pick_valid && be_in_valid[idx]) begin
                    pick_valid = 1'b1;
                    pick_idx   = BW'(idx);
                end
            end
        end

        // A held wormhole grant overrides the fresh round-robin pick.
        assign cur_valid = grant_valid || pick_valid;
        assign cur_idx   = grant_valid ? grant_idx : pick_idx;

        always_comb begin
            be_in_ready = '0;
            push_flit   = '0;
            push_last   = 1'b0;
            for (int g = 0; g < BE_PORTS; g++) begin
                if (cur_idx == BW'(g)) begin
                    be_in_ready[g] = cur_valid && !fifo_full && !rst;
                    push_flit      = be_in_flit[g*FW +: FW];
                    push_last      = be_in_last[g];
                end
            end
        end

        assign push         = |(be_in_valid & be_in_ready);
        assign be_out_valid = !tdm_out_valid && !fifo_empty;
        assign pop          = be_out_valid && be_out_ready;
        assign be_flit      = be_out_valid ? head_flit : '0;
        assign be_last      = be_out_valid && head_last;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                grant_valid <= 1'b0;
                grant_idx   <= '0;
                rr_ptr      <= '0;
            end else if (push) begin
                if (push_last) begin
                    grant_valid <= 1'b0;
                    rr_ptr      <= (cur_idx == BW'(BE_PORTS - 1)) ?
                                   '0 : cur_idx + 1'b1;
                end else begin
                    grant_valid <= 1'b1;
                    grant_idx   <= cur_idx;
                end
            end
        end

        noc_output_fifo #(
            .WIDTH (FW),
            .DEPTH (BUFFER_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push),
            .push_data (push_flit),
            .push_last (push_last),
            .pop       (pop),
            .head_data (head_flit),
            .head_last (head_last),
            .full      (fifo_full),
            .empty     (fifo_empty)
        );
    end else begin : g_no_be
        assign be_in_ready  = '0;
        assign be_out_valid = 1'b0;
        assign be_flit      = '0;
        assign be_last      = 1'b0;
    end

endmodule

// File: tb/tb_hybrid_noc_router_output.sv
// Directed bench for hybrid_noc_router_output: TDM slots, BE round-robin,
// pre-emption, back-pressure and mid-packet reset.
module tb_hybrid_noc_router_output;

    localparam int FW = 32;
    localparam int P  = 5;
    localparam int BP = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [P*FW-1:0] tdm_in_flit;
    logic [P-1:0]    tdm_in_valid;
    logic [P-1:0]    tdm_in_last;
    logic [BP*FW-1:0] be_in_flit;
    logic [BP-1:0]   be_in_valid;
    logic [BP-1:0]   be_in_last;
    logic [BP-1:0]   be_in_ready;
    logic [FW-1:0]   out_flit;
    logic            out_last;
    logic            tdm_out_valid;
    logic            be_out_valid;
    logic            be_out_ready;
    logic [2:0]      lut_conf_data;
    logic [2:0]      lut_conf_sel;
    logic [3:0]      lut_conf_slot;
    logic            lut_conf_valid;

    int errors = 0;
    int checks = 0;
    int tb_slot;

    hybrid_noc_router_output dut (
        .clk            (clk),
        .rst            (rst),
        .tdm_in_flit    (tdm_in_flit),
        .tdm_in_valid   (tdm_in_valid),
        .tdm_in_last    (tdm_in_last),
        .be_in_flit     (be_in_flit),
        .be_in_valid    (be_in_valid),
        .be_in_last     (be_in_last),
        .be_in_ready    (be_in_ready),
        .out_flit       (out_flit),
        .out_last       (out_last),
        .tdm_out_valid  (tdm_out_valid),
        .be_out_valid   (be_out_valid),
        .be_out_ready   (be_out_ready),
        .lut_conf_data  (lut_conf_data),
        .lut_conf_sel   (lut_conf_sel),
        .lut_conf_slot  (lut_conf_slot),
        .lut_conf_valid (lut_conf_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) tb_slot <= 0;
        else     tb_slot <= (tb_slot + 1) % 16;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_be(input int p, input logic v,
                          input logic [31:0] f, input logic l);
        be_in_valid[p]        = v;
        be_in_flit[p*FW +: FW] = f;
        be_in_last[p]         = l;
    endtask

    task automatic lut_write(input logic [2:0] sel, input logic [3:0] s,
                             input logic [2:0] d);
        @(negedge clk);
        lut_conf_sel   = sel;
        lut_conf_slot  = s;
        lut_conf_data  = d;
        lut_conf_valid = 1'b1;
        @(negedge clk);
        lut_conf_valid = 1'b0;
    endtask

    task automatic wait_slot(input int s);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (tb_slot == s) found = 1'b1;
        end
        if (!found) chk("wait_slot_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int seq [BP];
        logic [31:0] got [8];
        logic        gl [8];
        logic [31:0] rr_exp [8];
        int n;
        int idx;
        int acc;

        rr_exp = '{32'h000, 32'h001, 32'h200, 32'h201,
                   32'h002, 32'h003, 32'h202, 32'h203};

        rst            = 1'b1;
        tdm_in_valid   = '0;
        tdm_in_last    = '0;
        be_in_flit     = '0;
        be_in_valid    = '1;
        be_in_last     = '0;
        be_out_ready   = 1'b0;
        lut_conf_data  = '0;
        lut_conf_sel   = '0;
        lut_conf_slot  = '0;
        lut_conf_valid = 1'b0;
        for (int p = 0; p < P; p++)
            tdm_in_flit[p*FW +: FW] = 32'hBAD0_0000 | p;

        @(negedge clk);
        #1;
        chk("rst_tdm_valid", tdm_out_valid, 0);
        chk("rst_be_valid", be_out_valid, 0);
        chk("rst_out_flit", out_flit, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_be_ready", be_in_ready, 0);
        rst         = 1'b0;
        be_in_valid = '0;

        // Unconfigured LUT: every slot idle.
        tdm_in_valid = '1;
        repeat (16) begin
            @(negedge clk);
            chk("lut_idle", tdm_out_valid, 0);
        end
        tdm_in_valid = '0;

        lut_write(3'd1, 4'd3, 3'd2);
        tdm_in_valid = '1;
        repeat (16) begin
            @(negedge clk);
            chk("sel_ignored", tdm_out_valid, 0);
        end
        tdm_in_valid = '0;

        lut_write(3'd0, 4'd3, 3'd2);
        wait_slot(3);
        tdm_in_flit[2*FW +: FW] = 32'hA5A5_0003;
        tdm_in_last[2]          = 1'b1;
        tdm_in_valid            = 5'b00100;
        @(negedge clk);
        tdm_in_valid = '0;
        tdm_in_last  = '0;
        #1;
        chk("tdm_valid", tdm_out_valid, 1);
        chk("tdm_flit", out_flit, 32'hA5A5_0003);
        chk("tdm_last", out_last, 1);
        chk("tdm_be_valid", be_out_valid, 0);
        @(negedge clk);
        #1;
        chk("tdm_one_cycle", tdm_out_valid, 0);

        // Single 3-flit BE packet from input 1.
        be_out_ready = 1'b1;
        @(negedge clk);
        set_be(1, 1, 32'h11, 0);
        #1;
        chk("be1_ready", be_in_ready, 5'b00010);
        @(negedge clk);
        set_be(1, 1, 32'h12, 0);
        #1;
        chk("be1_v0", be_out_valid, 1);
        chk("be1_f0", out_flit, 32'h11);
        chk("be1_l0", out_last, 0);
        @(negedge clk);
        set_be(1, 1, 32'h13, 1);
        #1;
        chk("be1_v1", be_out_valid, 1);
        chk("be1_f1", out_flit, 32'h12);
        @(negedge clk);
        set_be(1, 0, 32'h0, 0);
        #1;
        chk("be1_v2", be_out_valid, 1);
        chk("be1_f2", out_flit, 32'h13);
        chk("be1_l2", out_last, 1);
        @(negedge clk);
        #1;
        chk("be1_done", be_out_valid, 0);
        chk("be1_idle_flit", out_flit, 0);

        // Fresh reset so the round-robin pointer starts at 0.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int p = 0; p < BP; p++) seq[p] = 0;
        n = 0;
        for (int c = 0; c < 40 && n < 8; c++) begin
            @(negedge clk);
            set_be(0, seq[0] < 4, 32'h000 | seq[0], seq[0][0]);
            set_be(2, seq[2] < 4, 32'h200 | seq[2], seq[2][0]);
            #1;
            chk("rr_onehot", {31'd0, $onehot0(be_in_ready)}, 1);
            if (be_out_valid) begin
                got[n] = out_flit;
                n++;
            end
            if (be_in_ready[0] && be_in_valid[0]) seq[0]++;
            if (be_in_ready[2] && be_in_valid[2]) seq[2]++;
        end
        set_be(0, 0, 0, 0);
        set_be(2, 0, 0, 0);
        chk("rr_count", n, 8);
        for (int i = 0; i < 8; i++)
            if (i < n) chk($sformatf("rr_order%0d", i), got[i], rr_exp[i]);

        // TDM slot 5 pre-empts an in-flight BE packet from input 3.
        lut_write(3'd0, 4'd5, 3'd0);
        tdm_in_flit[0 +: FW] = 32'hDEAD_0000;
        tdm_in_last[0]       = 1'b0;
        tdm_in_valid         = 5'b00001;
        wait_slot(2);
        set_be(3, 1, 32'h31, 0);
        #1;
        chk("pre_ready", be_in_ready, 5'b01000);
        @(negedge clk);
        set_be(3, 1, 32'h32, 0);
        #1;
        chk("pre_f31", out_flit, 32'h31);
        chk("pre_v31", be_out_valid, 1);
        @(negedge clk);
        set_be(3, 1, 32'h33, 0);
        #1;
        chk("pre_f32", out_flit, 32'h32);
        @(negedge clk);
        set_be(3, 1, 32'h34, 1);
        #1;
        chk("pre_f33", out_flit, 32'h33);
        chk("pre_tdm_before", tdm_out_valid, 0);
        @(negedge clk);
        set_be(3, 0, 0, 0);
        #1;
        chk("pre_tdm_valid", tdm_out_valid, 1);
        chk("pre_be_stall", be_out_valid, 0);
        chk("pre_tdm_flit", out_flit, 32'hDEAD_0000);
        @(negedge clk);
        #1;
        chk("pre_resume_v", be_out_valid, 1);
        chk("pre_resume_f", out_flit, 32'h34);
        chk("pre_resume_l", out_last, 1);
        chk("pre_resume_tdm", tdm_out_valid, 0);
        @(negedge clk);
        #1;
        chk("pre_done", be_out_valid, 0);
        tdm_in_valid = '0;

        // Back-pressure: depth-2 FIFO takes exactly two flits.
        be_out_ready = 1'b0;
        idx = 0;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            set_be(4, idx < 4, 32'h41 + idx, idx == 3);
            #1;
            if (be_in_ready[4] && be_in_valid[4]) begin
                acc++;
                idx++;
            end
        end
        chk("bp_accepted", acc, 2);
        chk("bp_ready_low", be_in_ready, 0);
        chk("bp_head_v", be_out_valid, 1);
        chk("bp_head_f", out_flit, 32'h41);
        n = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            @(negedge clk);
            be_out_ready = 1'b1;
            set_be(4, idx < 4, 32'h41 + idx, idx == 3);
            #1;
            if (be_out_valid) begin
                got[n] = out_flit;
                gl[n]  = out_last;
                n++;
            end
            if (be_in_ready[4] && be_in_valid[4]) idx++;
        end
        set_be(4, 0, 0, 0);
        chk("bp_drain_count", n, 4);
        for (int i = 0; i < 4; i++)
            if (i < n) chk($sformatf("bp_drain%0d", i), got[i], 32'h41 + i);
        if (n == 4) begin
            chk("bp_last_mid", gl[2], 0);
            chk("bp_last_end", gl[3], 1);
        end

        // Reset in the middle of a packet from input 1.
        be_out_ready = 1'b0;
        @(negedge clk);
        set_be(1, 1, 32'h51, 0);
        @(negedge clk);
        set_be(1, 1, 32'h52, 0);
        @(negedge clk);
        rst = 1'b1;
        set_be(1, 0, 0, 0);
        #1;
        chk("mrst_be_valid", be_out_valid, 0);
        chk("mrst_flit", out_flit, 0);
        chk("mrst_ready", be_in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        set_be(0, 1, 32'h61, 0);
        set_be(1, 1, 32'h62, 0);
        #1;
        chk("mrst_grant", be_in_ready, 5'b00001);
        chk("mrst_flush", be_out_valid, 0);
        set_be(0, 0, 0, 0);
        set_be(1, 0, 0, 0);
        tdm_in_valid = '1;
        repeat (16) begin
            @(negedge clk);
            chk("mrst_lut_idle", tdm_out_valid, 0);
        end
        tdm_in_valid = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
